msrv32_dmem_access_ctrl: RTL and testbench
==========================================

Name: msrv32_dmem_access_ctrl

Overview:
- Data-memory access controller between the execute/memory stage and the external AHB-lite-style data bus.
- Accepts one load/store request at a time and aligns store data into byte lanes with a write mask.
- Runs the address/data phases with wait states and an error/timeout check.
- Returns the raw read word plus an active-low response flag to the downstream load unit, which does the byte/half extraction. Stalls the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 16, max data-phase cycles with hready_in low before the access is aborted with an error (must be >= 2).
CNT_W, 5, timeout counter width (2**CNT_W > TIMEOUT_CYCLES).

Ports:
ms_riscv32_mp_clk_in  input  1  core clock, rising edge
ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset
req_valid_in  input  1  memory request from pipeline; held with its fields stable until req_ready_out
req_write_in  input  1  1 = store, 0 = load
req_size_in  input  2  00 byte, 01 half, 10/11 word
req_addr_in  input  32  byte address (iadder output)
req_wdata_in  input  32  store data (rs2), right-justified
req_ready_out  output  1  request accepted this cycle
dmtrans_out  output  1  bus address-phase valid
dmaddr_out  output  32  bus address, bits [1:0] forced to 00
dmwr_req_out  output  1  bus write enable
dmwr_mask_out  output  4  byte-lane write strobes
dmdata_out  output  32  lane-replicated store data
hready_in  input  1  bus data phase complete
hresp_in  input  1  1 = bus error
hrdata_in  input  32  bus read data
ms_riscv32_mp_dmdata_out  output  32  captured read word to load unit
ahb_resp_out  output  1  active-low: 0 = read data valid this cycle
rsp_valid_out  output  1  access completed (load or store), one cycle
err_out  output  1  misaligned, bus error or timeout; valid with rsp_valid_out
stall_out  output  1  hold pipeline

Behaviour:
- Clock and reset: one clock, ms_riscv32_mp_clk_in. Reset ms_riscv32_mp_rst_n_in is asynchronous, active-low.
- Reset state: FSM=IDLE, counter=0. All outputs 0 except ahb_resp_out=1. Reset mid-access abandons the access; no response is issued.
- FSM states: IDLE, ADDR, WAIT, DONE.
- IDLE:
  - req_ready_out = req_valid_in.
  - On accept, register addr, size, write, aligned data and mask.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=00) -> DONE with err, no bus activity.
  - Otherwise -> ADDR.
- ADDR (1 cycle): dmtrans_out=1; dmaddr_out, dmwr_req_out, dmwr_mask_out and dmdata_out driven from registers. -> WAIT.
- WAIT:
  - dmwr_req_out, dmwr_mask_out and dmdata_out are held; dmtrans_out=0.
  - hready_in=1: capture hrdata_in (loads only), err=hresp_in, -> DONE.
  - hready_in=0: counter++. When counter reaches TIMEOUT_CYCLES-1 -> DONE with err=1 and read word 0.
  - Counter clears on leaving WAIT.
- DONE (1 cycle):
  - rsp_valid_out=1, err_out=err.
  - ahb_resp_out=0 only if load and no error.
  - ms_riscv32_mp_dmdata_out holds the captured word until the next load capture.
  - -> IDLE. A new request may be accepted the following cycle.
- Store alignment:
  - byte: data={4{wdata[7:0]}}, mask=0001<<addr[1:0].
  - half: data={2{wdata[15:0]}}, mask=0011<<{addr[1],0}.
  - word: data=wdata, mask=1111.
- Loads: mask=0000, dmwr_req_out=0.
- stall_out = (state!=IDLE && state!=DONE) || (state==IDLE && req_valid_in).
- Latency: accept at cycle T, zero-wait bus -> rsp_valid_out at T+3. Each wait state adds one cycle.
- hready_in and hresp_in are ignored outside WAIT.

Test Plan:
- Load word addr 0x100, hrdata_in=0xDEADBEEF, hready_in=1 in first WAIT cycle -> dmtrans_out at T+1 with dmaddr_out=0x100; rsp_valid_out=1, ahb_resp_out=0, ms_riscv32_mp_dmdata_out=0xDEADBEEF at T+3; stall_out high T..T+2.
- Store byte 0xA5 to addr 0x203 -> dmaddr_out=0x200, dmwr_mask_out=1000, dmdata_out=0xA5A5A5A5, dmwr_req_out=1; rsp_valid_out=1, ahb_resp_out=1, err_out=0.
- Store half 0x1234 to 0x42 with 3 wait states -> mask 1100, data 0x12341234 held through WAIT; rsp_valid_out at T+6.
- Load half at 0x101 (misaligned) -> no dmtrans_out; rsp_valid_out with err_out=1 at T+1.
- hready_in stuck 0 -> err_out=1 after TIMEOUT_CYCLES WAIT cycles; hresp_in=1 on a completing load -> err_out=1, ahb_resp_out stays 1.
- Assert ms_riscv32_mp_rst_n_in low in WAIT -> outputs return to reset values immediately, no rsp_valid_out; the next request completes normally.

Source files
------------

// File: rtl/msrv32_dmem_access_ctrl.sv
// rtl/msrv32_dmem_access_ctrl.sv - single-outstanding data-memory access controller for the AHB-lite-style data bus
module msrv32_dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        req_valid_in,
    input  logic        req_write_in,
    input  logic [1:0]  req_size_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        req_ready_out,
    output logic        dmtrans_out,
    output logic [31:0] dmaddr_out,
    output logic        dmwr_req_out,
    output logic [3:0]  dmwr_mask_out,
    output logic [31:0] dmdata_out,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic        ahb_resp_out,
    output logic        rsp_valid_out,
    output logic        err_out,
    output logic        stall_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        mask_q, mask_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              misaligned;
    logic [31:0]       lane_data;
    logic [3:0]        lane_mask;

    always_comb begin
        misaligned = 1'b0;
        case (req_size_in)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr_in[0];
            default: misaligned = (req_addr_in[1:0] != 2'b00);
        endcase
    end

    // Replicate store data across all lanes; the strobes pick the live bytes.
    always_comb begin
        lane_data = 32'd0;
        lane_mask = 4'b0000;
        if (req_write_in) begin
            case (req_size_in)
                2'b00: begin
                    lane_data = {4{req_wdata_in[7:0]}};
                    lane_mask = 4'b0001 << req_addr_in[1:0];
                end
                2'b01: begin
                    lane_data = {2{req_wdata_in[15:0]}};
                    lane_mask = 4'b0011 << {req_addr_in[1], 1'b0};
                end
                default: begin
                    lane_data = req_wdata_in;
                    lane_mask = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            data_q  <= 32'd0;
            mask_q  <= 4'b0000;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        data_d  = data_q;
        mask_d  = mask_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        req_ready_out = 1'b0;
        dmtrans_out   = 1'b0;
        dmaddr_out    = 32'd0;
        dmwr_req_out  = 1'b0;
        dmwr_mask_out = 4'b0000;
        dmdata_out    = 32'd0;
        rsp_valid_out = 1'b0;
        err_out       = 1'b0;
        ahb_resp_out  = 1'b1;
        stall_out     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_out = req_valid_in;
                stall_out     = req_valid_in;
                if (req_valid_in) begin
                    addr_d  = req_addr_in;
                    write_d = req_write_in;
                    data_d  = lane_data;
                    mask_d  = lane_mask;
                    err_d   = misaligned;
                    state_d = misaligned ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                stall_out     = 1'b1;
                dmtrans_out   = 1'b1;
                dmaddr_out    = {addr_q[31:2], 2'b00};
                dmwr_req_out  = write_q;
                dmwr_mask_out = mask_q;
                dmdata_out    = data_q;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                stall_out     = 1'b1;
                dmaddr_out    = {addr_q[31:2], 2'b00};
                dmwr_req_out  = write_q;
                dmwr_mask_out = mask_q;
                dmdata_out    = data_q;
                if (hready_in) begin
                    err_d   = hresp_in;
                    if (!write_q) rdata_d = hrdata_in;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Bus never answered: abort with an error and a zeroed read word.
                    err_d   = 1'b1;
                    if (!write_q) rdata_d = 32'd0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                rsp_valid_out = 1'b1;
                err_out       = err_q;
                ahb_resp_out  = write_q | err_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ms_riscv32_mp_dmdata_out = rdata_q;

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// tb/tb_msrv32_dmem_access_ctrl.sv - directed vector bench for msrv32_dmem_access_ctrl
module tb_msrv32_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        dmtrans;
    logic [31:0] dmaddr;
    logic        dmwr_req;
    logic [3:0]  dmwr_mask;
    logic [31:0] dmdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] rd_word;
    logic        ahb_resp;
    logic        rsp_valid;
    logic        err;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    msrv32_dmem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_n_in   (rst_n),
        .req_valid_in             (req_valid),
        .req_write_in             (req_write),
        .req_size_in              (req_size),
        .req_addr_in              (req_addr),
        .req_wdata_in             (req_wdata),
        .req_ready_out            (req_ready),
        .dmtrans_out              (dmtrans),
        .dmaddr_out               (dmaddr),
        .dmwr_req_out             (dmwr_req),
        .dmwr_mask_out            (dmwr_mask),
        .dmdata_out               (dmdata),
        .hready_in                (hready),
        .hresp_in                 (hresp),
        .hrdata_in                (hrdata),
        .ms_riscv32_mp_dmdata_out (rd_word),
        .ahb_resp_out             (ahb_resp),
        .rsp_valid_out            (rsp_valid),
        .err_out                  (err),
        .stall_out                (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        int          waits;
        logic        hresp;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_data;
        int          e_trans;
        logic        e_err;
        logic        e_resp_n;
        logic [31:0] e_rd;
        int          e_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int  trans = 0;
        bit  done  = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.wr;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        hrdata    = v.hrdata;
        hready    = 1'b1;
        hresp     = 1'b0;
        #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        chk("stall_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            // hready high in ADDR too: it must be ignored there
            hready = (c == 1) || (c >= 2 + v.waits);
            hresp  = v.hresp;
            #1;
            if (dmtrans) begin
                trans++;
                chk("trans_cycle", c, 1);
                chk("dmaddr", dmaddr, v.e_addr);
                chk("dmwr_req", {31'd0, dmwr_req}, {31'd0, v.wr});
                chk("dmwr_mask", {28'd0, dmwr_mask}, {28'd0, v.e_mask});
                if (v.wr) chk("dmdata", dmdata, v.e_data);
            end else if (c >= 2 && !rsp_valid) begin
                chk("wait_addr_held", dmaddr, v.e_addr);
                chk("wait_mask_held", {28'd0, dmwr_mask}, {28'd0, v.e_mask});
                if (v.wr) chk("wait_data_held", dmdata, v.e_data);
            end
            if (rsp_valid) begin
                done = 1;
                chk("latency", c, v.e_lat);
                chk("err", {31'd0, err}, {31'd0, v.e_err});
                chk("ahb_resp", {31'd0, ahb_resp}, {31'd0, v.e_resp_n});
                chk("rd_word", rd_word, v.e_rd);
                chk("stall_done", {31'd0, stall}, 32'd0);
                chk("trans_count", trans, v.e_trans);
            end else begin
                chk("stall_busy", {31'd0, stall}, 32'd1);
            end
            @(negedge clk);
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected latency %0d", v.e_lat);
        end
        hready = 1'b1;
        hresp  = 1'b0;
        #1;
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ahb_resp", {31'd0, ahb_resp}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_dmtrans"}, {31'd0, dmtrans}, 32'd0);
        chk({tag, "_dmaddr"}, dmaddr, 32'd0);
        chk({tag, "_dmwr_req"}, {31'd0, dmwr_req}, 32'd0);
        chk({tag, "_dmwr_mask"}, {28'd0, dmwr_mask}, 32'd0);
        chk({tag, "_dmdata"}, dmdata, 32'd0);
        chk({tag, "_rd_word"}, rd_word, 32'd0);
        chk({tag, "_ahb_resp"}, {31'd0, ahb_resp}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        //          wr    sz     addr          wdata         hrdata        wt  hr    e_addr        mask     e_data        tr  er    rsp_n rd            lat
        vecs[0] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0,        0, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1'b1, 2'b01, 32'h0000_0042, 32'h0000_1234, 32'h0,        3, 1'b0, 32'h0000_0040, 4'b1100, 32'h1234_1234, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6};
        vecs[3] = '{1'b0, 2'b01, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1};
        vecs[4] = '{1'b0, 2'b10, 32'h0000_0080, 32'h0,        32'h9999_9999, 99, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,       1, 1'b1, 1'b1, 32'h0,         18};
        vecs[5] = '{1'b0, 2'b10, 32'h0000_0084, 32'h0,        32'h1122_3344, 1, 1'b1, 32'h0000_0084, 4'b0000, 32'h0,        1, 1'b1, 1'b1, 32'h1122_3344, 4};
        vecs[6] = '{1'b1, 2'b11, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 1, 1'b0, 1'b1, 32'h1122_3344, 3};
        vecs[7] = '{1'b0, 2'b00, 32'h0000_0007, 32'h0,        32'h5566_7788, 2, 1'b0, 32'h0000_0004, 4'b0000, 32'h0,        1, 1'b0, 1'b0, 32'h5566_7788, 5};
        vecs[8] = '{1'b1, 2'b10, 32'h0000_0022, 32'h0BAD_0BAD, 32'h0,        0, 1'b0, 32'h0000_0020, 4'b0000, 32'h0,        0, 1'b1, 1'b1, 32'h5566_7788, 1};
        vecs[9] = '{1'b1, 2'b00, 32'h0000_0001, 32'h1234_5677, 32'h0,        0, 1'b0, 32'h0000_0000, 4'b0010, 32'h7777_7777, 1, 1'b0, 1'b1, 32'h5566_7788, 3};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run(vecs[i]);

        // Reset while the bus is in a wait state: access is dropped silently.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        hready    = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_in_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n  = 1'b1;
        hready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        run(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
